// File: rtl/sha_pkg.sv
// Shared SHA-256 types, schedule constants and the small-sigma functions
// used by the message schedule expansion.
package sha_pkg;

    localparam int SHA_ROUNDS      = 64;
    localparam int SHA_BLOCK_WORDS = 16;

    typedef logic [31:0]  sha_word_t;
    typedef logic [511:0] sha_block_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic sha_word_t sigma0(input sha_word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic sha_word_t sigma1(input sha_word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha_schedule_window.sv
// Sliding 16-word window of the SHA-256 message schedule; w[0] is the word
// currently presented, w[15] receives the newly expanded word on each shift.
module sha_schedule_window
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  W
);

    sha_word_t w_r [SHA_BLOCK_WORDS];
    sha_word_t expand_s;

    // Next schedule word W_{t+16} from the window holding W_t..W_{t+15}.
    always_comb begin
        expand_s = sigma1(w_r[14]) + w_r[9] + sigma0(w_r[1]) + w_r[0];
    end

    // Window register: clear, load from block (W_0 in the top word), or shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
                w_r[i] <= 32'h0000_0000;
            end
        end else if (load) begin
            for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
                w_r[i] <= block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < SHA_BLOCK_WORDS - 1; i++) begin
                w_r[i] <= w_r[i + 1];
            end
            w_r[SHA_BLOCK_WORDS - 1] <= expand_s;
        end else begin
            for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
                w_r[i] <= w_r[i];
            end
        end
    end

    assign W = w_r[0];

endmodule

// File: rtl/sha_message_scheduler.sv
// SHA-256 message scheduler: block handshake, round counter and schedule feed.
// Optional abort input is enabled by defining SHA_SCHED_ABORT_EN.
module sha_message_scheduler
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
`ifdef SHA_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         block_valid,
    input  logic [511:0] block,
    output logic         block_ready,
    output logic [5:0]   counter,
    output logic [31:0]  W,
    output logic         done
);

    localparam logic [5:0] LAST_ROUND = 6'(SHA_ROUNDS - 1);

    sched_state_t state_r, state_s;
    logic [5:0]   counter_r, counter_s;
    logic         done_r, done_s;
    logic         abort_s, handshake_s, load_s, shift_s;

`ifdef SHA_SCHED_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign block_ready = (counter_r == 6'd0) && !rst && !abort_s;
    assign handshake_s = block_valid && block_ready;

    // Next state: a handshake always restarts at round 1 (covers the
    // zero-bubble reload at the wrap); done is set one cycle ahead so it
    // is registered yet lands on the cycle counter reads 0.
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        if (handshake_s) begin
            state_s   = ST_RUN;
            counter_s = 6'd1;
            load_s    = 1'b1;
        end else if ((state_r == ST_RUN) && !abort_s && (counter_r != 6'd0)) begin
            state_s   = ST_RUN;
            counter_s = counter_r + 6'd1;
            shift_s   = 1'b1;
            done_s    = (counter_r == LAST_ROUND);
        end else begin
            state_s   = ST_IDLE;
            counter_s = 6'd0;
        end
    end

    // State, counter and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            counter_r <= 6'd0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            done_r    <= done_s;
        end
    end

    sha_schedule_window u_window (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .block (block),
        .W     (W)
    );

    assign counter = counter_r;
    assign done    = done_r;

endmodule

// File: doc/sha_message_scheduler.md
# sha_message_scheduler

- Producer side of the SHA-256 compressor interface.
- Accepts one 512-bit message block through a valid/ready handshake and generates the 6-bit round counter the compressor is sequenced by.
- Expands the block on the fly into the 64-word schedule W_0..W_63, one word per cycle, timed to the compressor's consumption order.
- Sits between the block-padding front end and the compressor. It is the only driver of the compressor's counter and W inputs.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- block_valid  in  1  message block offered
- block  in  512  message block; block[511:480] is W_0, block[31:0] is W_15 (big-endian word order)
- block_ready  out  1  block accepted this cycle if block_valid also high
- counter  out  6  round counter to compressor
- W  out  32  schedule word to compressor
- done  out  1  one-cycle pulse; compressor hash output is valid this cycle

## Operation
- States:
  - IDLE: counter held at 0; compressor reloads its input hash state every cycle.
  - RUN: counter increments every cycle.
- block_ready = (counter == 0) && !rst.
- Handshake occurs when block_valid && block_ready.
- On handshake:
  - The 16-word window w[0..15] is loaded from block.
  - State goes to RUN; counter becomes 1 on the next cycle.
- In RUN, every cycle:
  - counter <= counter + 1, with wrap 63 -> 0.
  - The window shifts: w[i] <= w[i+1] for i < 15.
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], all mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- W = w[0] at all times. W_t is therefore presented in the cycle where counter == (t+1) mod 64: W_0 at counter 1, W_62 at counter 63, W_63 at counter 0.
- At the RUN cycle with counter == 0:
  - done = 1.
  - If a handshake occurs in that same cycle, the window reloads and RUN continues with counter 1 (back-to-back blocks, zero bubble).
  - Otherwise the state goes to IDLE and the window holds.
- IDLE holds the window and W unchanged. counter never rests at a nonzero value.

## Timing
- Reset values: counter = 0, W = 0 (window cleared), done = 0, state IDLE. block_ready = 0 while rst is high and 1 on the first cycle after rst deasserts.
- Latency:
  - Handshake at cycle T; W_0 at T+1; W_63 and done at T+64.
  - Throughput is one block per 64 cycles.
- rst mid-block: the next cycle is IDLE with counter 0, the window cleared, and no done pulse. The partial block is discarded.
- block_valid while block_ready is low is ignored. The producer holds block until a handshake occurs.
- Outputs are registered, except block_ready, which is combinational from counter and rst.

## Configuration
- SHA_SCHED_ABORT_EN:
  - Defined: adds input port abort (1 bit).
    - abort high during RUN forces counter to 0 and state to IDLE on the next cycle, with no done pulse.
    - block_ready is forced low in a cycle where abort is high.
    - rst has priority over abort.
  - Undefined: the abort port is absent, and a block always runs all 64 cycles unless rst is asserted.

## Structure
- Shared package sha_pkg holds:
  - the 32-bit word typedef;
  - the 512-bit block typedef;
  - the sigma0/sigma1 functions;
  - SHA_ROUNDS = 64;
  - SHA_BLOCK_WORDS = 16.
- Sub-module sha_schedule_window contains the 16-word shift register and expansion adder. Its ports are load, shift, block, and W.
- The top level contains the counter/state machine and the handshake logic.

## Test plan
- Reset, then idle 5 cycles -> counter = 0, W = 0, done = 0, block_ready = 1 throughout.
- Padded "abc" block (W_0 = 0x61626380, W_15 = 0x00000018, other words 0) accepted at T:
  - T+1: W = 0x61626380.
  - T+17: W = 0x61626380 (W_16).
  - T+18: W = 0x000F0000.
  - T+19: W = 0x7DA86405.
  - T+64: W = 0x12B1EDEB, counter = 0, done = 1.
- Back-to-back: block_valid held high with a second block -> the second handshake is at T+64, W_0 of block 2 appears at T+65, and counter never sticks at 0.
- block_valid asserted at counter 30 -> ignored; the accepting handshake is at counter 0 after done.
- rst asserted at counter 40 -> next cycle counter = 0, W = 0, no done pulse; a new block is then accepted normally.
- With SHA_SCHED_ABORT_EN: abort at counter 20 -> next cycle counter = 0, state IDLE, no done pulse, block_ready = 1.
